// File: rtl/ysyx_22040088_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22040088_fetch_queue
// Purpose  : Instruction fetch front end. It issues sequential fetch requests
//            under a credit limit and buffers in-order responses in a small
//            queue for decode. Redirects flush the queue and discard stale
//            responses. Delivering an ebreak to decode halts fetch.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22040088_fetch_queue #(
  parameter int                XLEN     = 64,
  parameter int                ILEN     = 32,
  parameter int                DEPTH    = 4,
  parameter logic [XLEN-1:0]   RESET_PC = 64'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [ILEN-1:0] imem_resp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [ILEN-1:0] out_inst,
  output logic            halt
);

  localparam int              PW      = $clog2(DEPTH);
  localparam int              CW      = PW + 1;
  localparam logic [CW:0]     DEPTH_C = (CW+1)'(DEPTH);
  localparam logic [ILEN-1:0] EBREAK  = ILEN'(32'h0010_0073);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t          state_q;
  logic [XLEN-1:0] fetch_pc_q,  fetch_pc_d;
  logic [CW-1:0]   count_q,     count_d;
  logic [CW-1:0]   inflight_q,  inflight_d;
  logic [CW-1:0]   drop_cnt_q,  drop_cnt_d;
  logic [PW-1:0]   q_wr_ptr_q,  q_wr_ptr_d;
  logic [PW-1:0]   q_rd_ptr_q,  q_rd_ptr_d;
  logic [PW-1:0]   pf_wr_ptr_q, pf_wr_ptr_d;
  logic [PW-1:0]   pf_rd_ptr_q, pf_rd_ptr_d;

  // Storage arrays: contents are don't-care until written, so no reset.
  logic [XLEN-1:0] q_pc_mem   [DEPTH];
  logic [ILEN-1:0] q_inst_mem [DEPTH];
  logic [XLEN-1:0] pf_pc_mem  [DEPTH];

  logic req_fire;
  logic resp_fire;
  logic resp_keep;
  logic out_fire;
  logic ebreak_fire;

  // Handshakes and output views; request credit counts queued plus in-flight.
  always_comb begin
    halt           = (state_q == ST_HALT);
    imem_req_valid = rst && !halt && !redirect_valid &&
                     (({1'b0, count_q} + {1'b0, inflight_q}) < DEPTH_C);
    imem_req_addr  = fetch_pc_q;
    out_valid      = !halt && (count_q != '0);
    out_pc         = q_pc_mem[q_rd_ptr_q];
    out_inst       = q_inst_mem[q_rd_ptr_q];
    req_fire       = imem_req_valid && imem_req_ready;
    resp_fire      = imem_resp_valid;
    out_fire       = out_valid && out_ready;
    // A response is stored only if it is not stale and no flush happens now.
    resp_keep      = resp_fire && (drop_cnt_q == '0) && !redirect_valid;
    ebreak_fire    = out_fire && (out_inst == EBREAK);
  end

  // Next-state computation for pointers, counters and the fetch PC.
  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    count_d     = count_q;
    inflight_d  = inflight_q;
    drop_cnt_d  = drop_cnt_q;
    q_wr_ptr_d  = q_wr_ptr_q;
    q_rd_ptr_d  = q_rd_ptr_q;
    pf_wr_ptr_d = pf_wr_ptr_q;
    pf_rd_ptr_d = pf_rd_ptr_q;
    if (redirect_valid) begin
      // Flush wins; every request still outstanding becomes a stale response.
      fetch_pc_d  = redirect_pc;
      count_d     = '0;
      q_wr_ptr_d  = '0;
      q_rd_ptr_d  = '0;
      pf_wr_ptr_d = '0;
      pf_rd_ptr_d = '0;
      inflight_d  = inflight_q - CW'(resp_fire);
      drop_cnt_d  = inflight_q - CW'(resp_fire);
    end else begin
      if (req_fire) begin
        fetch_pc_d  = fetch_pc_q + XLEN'(4);
        pf_wr_ptr_d = pf_wr_ptr_q + PW'(1);
      end
      if (resp_fire) begin
        if (drop_cnt_q != '0) begin
          drop_cnt_d = drop_cnt_q - CW'(1);
        end else begin
          q_wr_ptr_d  = q_wr_ptr_q + PW'(1);
          pf_rd_ptr_d = pf_rd_ptr_q + PW'(1);
        end
      end
      if (out_fire) begin
        q_rd_ptr_d = q_rd_ptr_q + PW'(1);
      end
      count_d    = count_q + CW'(resp_keep) - CW'(out_fire);
      inflight_d = inflight_q + CW'(req_fire) - CW'(resp_fire);
    end
  end

  // Control registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q  <= RESET_PC;
      count_q     <= '0;
      inflight_q  <= '0;
      drop_cnt_q  <= '0;
      q_wr_ptr_q  <= '0;
      q_rd_ptr_q  <= '0;
      pf_wr_ptr_q <= '0;
      pf_rd_ptr_q <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      count_q     <= count_d;
      inflight_q  <= inflight_d;
      drop_cnt_q  <= drop_cnt_d;
      q_wr_ptr_q  <= q_wr_ptr_d;
      q_rd_ptr_q  <= q_rd_ptr_d;
      pf_wr_ptr_q <= pf_wr_ptr_d;
      pf_rd_ptr_q <= pf_rd_ptr_d;
    end
  end

  // Fetch-mode FSM; HALT is sticky until reset, even across redirects.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (ebreak_fire)             state_q <= ST_HALT;
          else if (drop_cnt_d != '0)   state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (ebreak_fire)             state_q <= ST_HALT;
          else if (drop_cnt_d == '0)   state_q <= ST_RUN;
        end
        default: state_q <= ST_HALT;
      endcase
    end
  end

  // Data storage: PC of each issued request, then {pc, inst} of kept responses.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      pf_pc_mem[pf_wr_ptr_q] <= fetch_pc_q;
    end
    if (resp_keep) begin
      q_pc_mem[q_wr_ptr_q]   <= pf_pc_mem[pf_rd_ptr_q];
      q_inst_mem[q_wr_ptr_q] <= imem_resp_data;
    end
  end

endmodule
`default_nettype wire

// File: doc/ysyx_22040088_fetch_queue.md
YSYX_22040088_FETCH_QUEUE -- requirements
Module: ysyx_22040088_fetch_queue

Interface
REQ-001 Parameter XLEN, default 64, PC/address width.
REQ-002 Parameter ILEN, default 32, instruction width.
REQ-003 Parameter DEPTH, default 4, queue entries and max in-flight requests; power of two, >=2.
REQ-004 Parameter RESET_PC, default 64'h8000_0000, first fetch address.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low (0 = reset).
REQ-007 redirect_valid  in  1  flush and restart fetch at redirect_pc.
REQ-008 redirect_pc  in  XLEN  new fetch address.
REQ-009 imem_req_valid  out  1  fetch request.
REQ-010 imem_req_ready  in  1  memory accepts request.
REQ-011 imem_req_addr  out  XLEN  fetch address.
REQ-012 imem_resp_valid  in  1  response beat, in request order.
REQ-013 imem_resp_data  in  ILEN  fetched instruction.
REQ-014 out_valid  out  1  queue head valid.
REQ-015 out_ready  in  1  decode consumes head.
REQ-016 out_pc  out  XLEN  head PC.
REQ-017 out_inst  out  ILEN  head instruction.
REQ-018 halt  out  1  sticky; ebreak delivered to decode.

Function
REQ-019 Request handshake: request fires when imem_req_valid && imem_req_ready; response fires when imem_resp_valid; output fires when out_valid && out_ready.
REQ-020 imem_req_valid = !halt && !redirect_valid && (count + inflight) < DEPTH; depends on no input other than redirect_valid.
REQ-021 imem_req_addr = fetch_pc; fetch_pc += 4 on each request fire.
REQ-022 inflight increments on request fire, decrements on response fire; both same cycle -> unchanged.
REQ-023 Each non-dropped response fire writes {pc, data} into tail entry; pc taken from a DEPTH-deep in-flight PC FIFO pushed on request fire.
REQ-024 Output side: out_valid = (count != 0); out_pc/out_inst = head entry; head advances on output fire.
REQ-025 Simultaneous response write and output fire: count unchanged; write to full queue is impossible by REQ-020 credit rule.
REQ-026 Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
REQ-027 Bypass: none; a response is visible at out_* no earlier than the cycle after its response fire (min latency req->out = 2 cycles with 1-cycle memory).
REQ-028 Redirect (redirect_valid=1, cycle N): queue and in-flight PC FIFO emptied, count=0, fetch_pc=redirect_pc, drop_cnt=inflight (minus 1 if a response fires in cycle N); out_valid=0 in cycle N+1.
REQ-029 While drop_cnt != 0, each response fire decrements drop_cnt and is discarded; new requests may issue meanwhile and credits still count dropped in-flight.
REQ-030 Redirect has priority over request, response and output fire in the same cycle; an output fire in cycle N still counts as consumed.
REQ-031 Ebreak: on output fire of out_inst == 32'h0010_0073, halt=1 from next cycle; halt clears only by reset.
REQ-032 When halt=1: no new requests; outstanding responses still absorbed; out_valid forced 0.
REQ-033 redirect_valid while halt=1 flushes state but does not clear halt.
REQ-034 State machine states: RUN (normal), DRAIN (drop_cnt!=0), HALT; RUN->DRAIN on redirect with inflight>0, DRAIN->RUN when drop_cnt reaches 0, any->HALT on ebreak fire.

Reset
REQ-035 While rst=0, asynchronously: fetch_pc=RESET_PC, count=0, inflight=0, drop_cnt=0, pointers=0, halt=0, state=RUN.
REQ-036 Reset values of outputs: imem_req_valid=0 during reset, out_valid=0, halt=0, imem_req_addr=RESET_PC, out_pc/out_inst don't care.
REQ-037 Reset deassertion mid-transaction: responses for pre-reset requests are not produced by the bench; none are dropped.

Verification
REQ-038 Reset release, memory ready=1, 1-cycle latency, out_ready=1 -> addresses 8000_0000, _0004, _0008 ... one per cycle; out_pc matches each in order, 2-cycle latency.
REQ-039 out_ready=0, memory always ready -> exactly DEPTH (4) requests issued, then imem_req_valid=0; count=4; after 1 output fire, one new request issues next cycle.
REQ-040 3 requests in flight, redirect_pc=8000_0100 -> 3 following responses discarded, first out_pc = 8000_0100.
REQ-041 Response, output fire and redirect in same cycle -> queue empty next cycle, fetch_pc=redirect_pc, drop_cnt=inflight-1.
REQ-042 Stream containing 0010_0073 at 8000_0008 -> halt=1 the cycle after it is consumed, no further requests, redirect leaves halt=1.
REQ-043 Random memory stalls/latency 1-5, random out_ready and redirects, DEPTH=2 and 8 -> delivered PC sequence equals reference model, no overflow, inflight never exceeds DEPTH.
